key_conditioner: RTL and testbench



---
 rtl/key_conditioner_pkg.sv | 27 ++
 rtl/key_conditioner_debounce_cell.sv | 58 +++++
 rtl/key_conditioner.sv | 215 +++++++++++++++++++++
 tb/tb_key_conditioner.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_conditioner_pkg.sv
// key_conditioner_pkg
//   Shared constants and types for the key conditioning stage and the
//   controller that consumes its outputs.
//   - NoteKeyBits / LengthKeyBits : bus widths shared with the controller
//   - Btn*                        : push-button bit indices
//   - DefCyclesPerMs              : default 1 ms tick divisor (100 MHz clock)
//   - rep_state_e                 : auto-repeat FSM states
package key_conditioner_pkg;

   localparam int unsigned NoteKeyBits    = 7;
   localparam int unsigned LengthKeyBits  = 7;
   localparam int unsigned BtnBits        = 4;

   localparam int unsigned BtnSubmit      = 0;
   localparam int unsigned BtnCancel      = 1;
   localparam int unsigned BtnOctUp       = 2;
   localparam int unsigned BtnOctDown     = 3;

   localparam int unsigned DefCyclesPerMs = 100000;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StRepeat
   } rep_state_e;

endpackage

// File: rtl/key_conditioner_debounce_cell.sv
// key_conditioner_debounce_cell
//   One raw input bit: 2-FF synchroniser followed by a tick-driven debounce
//   counter. A new level is accepted on the DEBOUNCE_MS-th tick of an
//   uninterrupted mismatch; any return to the stable level clears progress.
//   Ports:
//     clk_i    : system clock
//     rst_ni   : asynchronous active-low reset
//     raw_i    : raw, asynchronous input bit
//     tick_i   : one-cycle 1 ms strobe
//     stable_o : debounced level
module key_conditioner_debounce_cell #(
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_i,
   input  logic tick_i,
   output logic stable_o
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (32'(cnt_q) + 32'd1 == DEBOUNCE_MS) begin
            stable_d = sync2_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner
//   Synchronises and debounces note keys, length switches and push-buttons,
//   then presents clean levels, a one-hot note, and press pulses with
//   auto-repeat on the two octave buttons.
//   Ports:
//     clk_i         : system clock
//     rst_ni        : asynchronous active-low reset
//     raw_note_i    : raw note switches, active high
//     raw_length_i  : raw length switches, active high
//     raw_btn_i     : raw push-buttons (submit, cancel, oct_up, oct_down)
//     note_key_o    : one-hot lowest pressed debounced note, or zero
//     note_multi_o  : more than one debounced note pressed
//     note_change_o : one-cycle pulse when note_key_o changes
//     length_key_o  : debounced length switch levels
//     btn_level_o   : debounced button levels
//     btn_pulse_o   : one-cycle press pulses, auto-repeat on octave buttons
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int unsigned NOTE_KEY_BITS   = NoteKeyBits,
   parameter int unsigned BTN_BITS        = BtnBits,
   parameter int unsigned CYCLES_PER_MS   = DefCyclesPerMs,
   parameter int unsigned DEBOUNCE_MS     = 20,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 150
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NOTE_KEY_BITS-1:0] raw_note_i,
   input  logic [NOTE_KEY_BITS-1:0] raw_length_i,
   input  logic [BTN_BITS-1:0]      raw_btn_i,
   output logic [NOTE_KEY_BITS-1:0] note_key_o,
   output logic                     note_multi_o,
   output logic                     note_change_o,
   output logic [NOTE_KEY_BITS-1:0] length_key_o,
   output logic [BTN_BITS-1:0]      btn_level_o,
   output logic [BTN_BITS-1:0]      btn_pulse_o
);

   localparam int unsigned NumCells = 2 * NOTE_KEY_BITS + BTN_BITS;
   localparam int unsigned TickW    = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam int unsigned RepMax   = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                      REPEAT_DELAY_MS : REPEAT_RATE_MS;
   localparam int unsigned RepW     = $clog2(RepMax + 1);
   localparam int unsigned NumRep   = 2;

   // ---------------------------------------------------------------------
   // 1 ms tick
   // ---------------------------------------------------------------------
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             tick;

   assign tick       = (tick_cnt_q == TickW'(CYCLES_PER_MS - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // Per-bit synchronise + debounce
   // ---------------------------------------------------------------------
   logic [NumCells-1:0]      raw_all;
   logic [NumCells-1:0]      stable_all;
   logic [NOTE_KEY_BITS-1:0] stable_note;
   logic [NOTE_KEY_BITS-1:0] stable_length;
   logic [BTN_BITS-1:0]      stable_btn;

   assign raw_all = {raw_btn_i, raw_length_i, raw_note_i};

   for (genvar gi = 0; gi < NumCells; gi++) begin : g_cell
      key_conditioner_debounce_cell #(
         .DEBOUNCE_MS (DEBOUNCE_MS)
      ) u_cell (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .raw_i    (raw_all[gi]),
         .tick_i   (tick),
         .stable_o (stable_all[gi])
      );
   end

   assign stable_note   = stable_all[NOTE_KEY_BITS-1:0];
   assign stable_length = stable_all[2*NOTE_KEY_BITS-1:NOTE_KEY_BITS];
   assign stable_btn    = stable_all[NumCells-1:2*NOTE_KEY_BITS];

   // ---------------------------------------------------------------------
   // Note priority encode (lowest index wins) and multi-press detect
   // ---------------------------------------------------------------------
   logic [NOTE_KEY_BITS-1:0] note_key_q, note_key_d;
   logic                     note_multi_q, note_multi_d;
   logic                     note_change_q, note_change_d;
   logic [NOTE_KEY_BITS-1:0] length_key_q;

   always_comb begin
      int unsigned ones;
      logic        found;
      ones       = 0;
      found      = 1'b0;
      note_key_d = '0;
      for (int i = 0; i < int'(NOTE_KEY_BITS); i++) begin
         if (stable_note[i]) begin
            ones = ones + 1;
            if (!found) begin
               note_key_d[i] = 1'b1;
               found         = 1'b1;
            end
         end
      end
      note_multi_d  = (ones > 1);
      note_change_d = (note_key_d != note_key_q);
   end

   // ---------------------------------------------------------------------
   // Auto-repeat FSMs for oct_up / oct_down (index r -> button BtnOctUp + r)
   // ---------------------------------------------------------------------
   rep_state_e      rep_state_q [NumRep];
   rep_state_e      rep_state_d [NumRep];
   logic [RepW-1:0] rep_cnt_q   [NumRep];
   logic [RepW-1:0] rep_cnt_d   [NumRep];
   logic [NumRep-1:0] rep_fire;
   logic [BTN_BITS-1:0] btn_level_q;
   logic [BTN_BITS-1:0] btn_pulse_q, btn_pulse_d;

   always_comb begin
      for (int r = 0; r < int'(NumRep); r++) begin
         rep_state_d[r] = rep_state_q[r];
         rep_cnt_d[r]   = rep_cnt_q[r];
         rep_fire[r]    = 1'b0;
         if (!btn_level_q[int'(BtnOctUp) + r]) begin
            rep_state_d[r] = StIdle;
            rep_cnt_d[r]   = '0;
         end else begin
            unique case (rep_state_q[r])
               StIdle: begin
                  rep_state_d[r] = StHold;
                  rep_cnt_d[r]   = '0;
               end
               StHold: begin
                  if (tick) begin
                     if (32'(rep_cnt_q[r]) + 32'd1 == REPEAT_DELAY_MS) begin
                        rep_fire[r]    = 1'b1;
                        rep_cnt_d[r]   = '0;
                        rep_state_d[r] = StRepeat;
                     end else begin
                        rep_cnt_d[r] = rep_cnt_q[r] + RepW'(1);
                     end
                  end
               end
               StRepeat: begin
                  if (tick) begin
                     if (32'(rep_cnt_q[r]) + 32'd1 == REPEAT_RATE_MS) begin
                        rep_fire[r]  = 1'b1;
                        rep_cnt_d[r] = '0;
                     end else begin
                        rep_cnt_d[r] = rep_cnt_q[r] + RepW'(1);
                     end
                  end
               end
               default: begin
                  rep_state_d[r] = StIdle;
                  rep_cnt_d[r]   = '0;
               end
            endcase
         end
      end
   end

   // Press pulses coincide with the rising edge of btn_level; repeat pulses
   // come from the FSMs, which cannot fire until at least one tick later.
   always_comb begin
      btn_pulse_d = stable_btn & ~btn_level_q;
      for (int r = 0; r < int'(NumRep); r++) begin
         btn_pulse_d[int'(BtnOctUp) + r] = btn_pulse_d[int'(BtnOctUp) + r] | rep_fire[r];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         note_key_q    <= '0;
         note_multi_q  <= 1'b0;
         note_change_q <= 1'b0;
         length_key_q  <= '0;
         btn_level_q   <= '0;
         btn_pulse_q   <= '0;
         for (int r = 0; r < int'(NumRep); r++) begin
            rep_state_q[r] <= StIdle;
            rep_cnt_q[r]   <= '0;
         end
      end else begin
         note_key_q    <= note_key_d;
         note_multi_q  <= note_multi_d;
         note_change_q <= note_change_d;
         length_key_q  <= stable_length;
         btn_level_q   <= stable_btn;
         btn_pulse_q   <= btn_pulse_d;
         for (int r = 0; r < int'(NumRep); r++) begin
            rep_state_q[r] <= rep_state_d[r];
            rep_cnt_q[r]   <= rep_cnt_d[r];
         end
      end
   end

   assign note_key_o    = note_key_q;
   assign note_multi_o  = note_multi_q;
   assign note_change_o = note_change_q;
   assign length_key_o  = length_key_q;
   assign btn_level_o   = btn_level_q;
   assign btn_pulse_o   = btn_pulse_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Bench for key_conditioner with a short tick (10 cycles) and small
//   debounce / repeat constants. A behavioural model tracks each bit's
//   synchronised value, mismatch tick count and accepted level; repeat pulses
//   are derived from the number of ticks a button has been held.
module tb_key_conditioner;

   localparam int unsigned CPM = 10;
   localparam int unsigned DB  = 3;
   localparam int unsigned RD  = 5;
   localparam int unsigned RR  = 2;
   localparam int unsigned NB  = 7;
   localparam int unsigned BB  = 4;
   localparam int unsigned NC  = 2 * NB + BB;

   logic          clk;
   logic          rst_n;
   logic [NB-1:0] raw_note;
   logic [NB-1:0] raw_length;
   logic [BB-1:0] raw_btn;
   logic [NB-1:0] note_key;
   logic          note_multi;
   logic          note_change;
   logic [NB-1:0] length_key;
   logic [BB-1:0] btn_level;
   logic [BB-1:0] btn_pulse;

   key_conditioner #(
      .NOTE_KEY_BITS   (NB),
      .BTN_BITS        (BB),
      .CYCLES_PER_MS   (CPM),
      .DEBOUNCE_MS     (DB),
      .REPEAT_DELAY_MS (RD),
      .REPEAT_RATE_MS  (RR)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .raw_note_i    (raw_note),
      .raw_length_i  (raw_length),
      .raw_btn_i     (raw_btn),
      .note_key_o    (note_key),
      .note_multi_o  (note_multi),
      .note_change_o (note_change),
      .length_key_o  (length_key),
      .btn_level_o   (btn_level),
      .btn_pulse_o   (btn_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int prints = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (prints < 40) begin
            prints++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------
   logic [NC-1:0] m_s1, m_s2, m_stab, m_nstab;
   int            m_cnt [NC];
   int            m_tc;
   logic          m_tick;
   logic [NB-1:0] m_note, m_len, m_low;
   logic          m_multi, m_chg;
   logic [BB-1:0] m_lvl, m_pulse;
   int            m_age [2];
   int            m_held_ticks [2];
   logic [1:0]    m_fire;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_stab = '0; m_tc = 0;
         for (int i = 0; i < int'(NC); i++) m_cnt[i] = 0;
         m_note = '0; m_len = '0; m_multi = 1'b0; m_chg = 1'b0;
         m_lvl = '0; m_pulse = '0;
         for (int r = 0; r < 2; r++) begin
            m_age[r] = 0; m_held_ticks[r] = 0;
         end
      end else begin
         m_tick = (m_tc == int'(CPM) - 1);
         // registered outputs follow the accepted levels one cycle later
         m_low = '0;
         for (int i = 0; i < int'(NB); i++)
            if (m_stab[i] && m_low == '0) m_low[i] = 1'b1;
         m_chg   = (m_low != m_note);
         m_note  = m_low;
         m_multi = ($countones(m_stab[NB-1:0]) > 1);
         m_len   = m_stab[2*NB-1:NB];
         // repeat pulses: the Nth tick counted while held, N = RD, RD+RR, ...
         for (int r = 0; r < 2; r++) begin
            m_fire[r] = 1'b0;
            if (!m_lvl[2+r]) begin
               m_age[r] = 0;
               m_held_ticks[r] = 0;
            end else begin
               if (m_age[r] >= 1 && m_tick) begin
                  m_held_ticks[r]++;
                  m_fire[r] = (m_held_ticks[r] == int'(RD)) ||
                              (m_held_ticks[r] > int'(RD) &&
                               (m_held_ticks[r] - int'(RD)) % int'(RR) == 0);
               end
               m_age[r]++;
            end
         end
         m_pulse = (m_stab[NC-1:2*NB] & ~m_lvl) | {m_fire, 2'b00};
         m_lvl   = m_stab[NC-1:2*NB];
         // debounce: count ticks of uninterrupted mismatch
         m_nstab = m_stab;
         for (int i = 0; i < int'(NC); i++) begin
            if (m_s2[i] == m_stab[i]) m_cnt[i] = 0;
            else if (m_tick) begin
               m_cnt[i]++;
               if (m_cnt[i] == int'(DB)) begin
                  m_nstab[i] = m_s2[i];
                  m_cnt[i]   = 0;
               end
            end
         end
         m_stab = m_nstab;
         m_s2   = m_s1;
         m_s1   = {raw_btn, raw_length, raw_note};
         m_tc   = m_tick ? 0 : m_tc + 1;
      end
   end

   // ------------------------------------------------------------------
   // Per-cycle compare and pulse counters
   // ------------------------------------------------------------------
   int pcnt [BB];
   int chg_cnt = 0;
   initial for (int b = 0; b < int'(BB); b++) pcnt[b] = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         check("note_key",    32'(note_key),    32'(m_note));
         check("note_multi",  32'(note_multi),  32'(m_multi));
         check("note_change", 32'(note_change), 32'(m_chg));
         check("length_key",  32'(length_key),  32'(m_len));
         check("btn_level",   32'(btn_level),   32'(m_lvl));
         check("btn_pulse",   32'(btn_pulse),   32'(m_pulse));
         for (int b = 0; b < int'(BB); b++) pcnt[b] += int'(btn_pulse[b]);
         chg_cnt += int'(note_change);
      end
   end

   // Inputs change 2 time units after the falling edge, away from both the
   // compare point and the active edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_note_key"},   32'(note_key),    32'h0);
      check({tag, "_note_multi"}, 32'(note_multi),  32'h0);
      check({tag, "_note_chg"},   32'(note_change), 32'h0);
      check({tag, "_length"},     32'(length_key),  32'h0);
      check({tag, "_level"},      32'(btn_level),   32'h0);
      check({tag, "_pulse"},      32'(btn_pulse),   32'h0);
   endtask

   int k, gap, base0, base2, base_chg;
   logic found;

   initial begin
      rst_n      = 1'b0;
      raw_note   = '1;
      raw_length = '1;
      raw_btn    = '1;

      // Reset with every input high: all outputs held at zero.
      cyc(3);
      check_all_zero("in_reset");

      // Release with inputs held: all four buttons pulse together.
      rst_n = 1'b1;
      found = 1'b0;
      k = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         cyc(1);
         k++;
         if (btn_pulse === 4'b1111) found = 1'b1;
      end
      check("rst_pulse_seen", 32'(found), 32'd1);
      check("rst_pulse_delay_ok", 32'(k >= 21 && k <= 33), 32'd1);

      raw_note = '0; raw_length = '0; raw_btn = '0;
      cyc(60);

      // Bounce on submit: only the steady hold is accepted; a lone 15-cycle
      // pulse never spans three ticks.
      base0 = pcnt[0];
      raw_btn[0] = 1'b1; cyc(15);
      raw_btn[0] = 1'b0; cyc(5);
      raw_btn[0] = 1'b1; cyc(60);
      raw_btn[0] = 1'b0; cyc(60);
      raw_btn[0] = 1'b1; cyc(15);
      raw_btn[0] = 1'b0; cyc(60);
      check("bounce_submit_pulses", 32'(pcnt[0] - base0), 32'd1);

      // Note priority.
      base_chg = chg_cnt;
      raw_note = 7'b0010100; cyc(50);
      check("prio_key",   32'(note_key),   32'h04);
      check("prio_multi", 32'(note_multi), 32'd1);
      raw_note = 7'b0010000; cyc(50);
      check("prio_key2",   32'(note_key),   32'h10);
      check("prio_multi2", 32'(note_multi), 32'd0);
      check("prio_changes", 32'(chg_cnt - base_chg), 32'd2);
      raw_note = '0; cyc(50);

      // Auto-repeat: btn_level stays high exactly 110 cycles, so 11 ticks are
      // counted while held -> repeats on ticks 5,7,9,11 plus the press.
      base2 = pcnt[2];
      raw_btn[2] = 1'b1; cyc(110);
      raw_btn[2] = 1'b0; cyc(60);
      check("repeat_octup_pulses", 32'(pcnt[2] - base2), 32'd5);
      base0 = pcnt[0];
      raw_btn[0] = 1'b1; cyc(110);
      raw_btn[0] = 1'b0; cyc(60);
      check("submit_no_repeat", 32'(pcnt[0] - base0), 32'd1);

      // Reset while oct_down is repeating.
      raw_btn[3] = 1'b1; cyc(95);
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      cyc(3);
      rst_n = 1'b1;
      found = 1'b0;
      k = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         cyc(1);
         k++;
         if (btn_pulse[3] === 1'b1) found = 1'b1;
      end
      check("rerst_press_seen", 32'(found), 32'd1);
      check("rerst_press_delay_ok", 32'(k >= 21 && k <= 33), 32'd1);
      found = 1'b0;
      gap = 0;
      for (int i = 0; i < 80 && !found; i++) begin
         cyc(1);
         gap++;
         if (btn_pulse[3] === 1'b1) found = 1'b1;
      end
      // press at tick edge T+1, first repeat on the 5th tick at T+50
      check("rerst_first_repeat_gap", 32'(gap), 32'd49);
      raw_btn[3] = 1'b0; cyc(60);

      // Length passthrough and glitch rejection.
      raw_length = 7'b0001000; cyc(50);
      check("length_set", 32'(length_key), 32'h08);
      raw_length = 7'b0001001; cyc(1);
      raw_length = 7'b0001000; cyc(50);
      check("length_glitch", 32'(length_key), 32'h08);

      // Randomised stimulus against the model.
      for (int s = 0; s < 70; s++) begin
         raw_note   = 7'($urandom);
         raw_length = 7'($urandom);
         raw_btn    = 4'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 1'b0;
            cyc(2);
            rst_n = 1'b1;
         end
         cyc(int'($urandom_range(1, 45)));
      end
      raw_note = '0; raw_length = '0; raw_btn = '0;
      cyc(60);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
